// File: rtl/wb_commit_stage.sv
// Writeback/commit stage: picks the writeback value for each retiring
// instruction and drives the register file's edge-triggered write port
// with a setup cycle followed by a single-cycle strobe. Also exports a
// forwarding entry, a misaligned-load error pulse and a commit counter.
module wb_commit_stage #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mem_valid,
    output logic              mem_ready,
    input  logic              mem_reg_write,
    input  logic [4:0]        mem_rd_addr,
    input  logic [1:0]        mem_wb_sel,
    input  logic [2:0]        mem_load_type,
    input  logic [DATA_W-1:0] mem_alu_result,
    input  logic [DATA_W-1:0] mem_load_data,
    input  logic [DATA_W-1:0] mem_pc_plus4,
    output logic [4:0]        reg_wr_addr,
    output logic [DATA_W-1:0] reg_wr_data,
    output logic              reg_wr_strobe,
    output logic              fwd_valid,
    output logic [4:0]        fwd_addr,
    output logic [DATA_W-1:0] fwd_data,
    output logic              err_misalign,
    output logic [CNT_W-1:0]  commit_count
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        STROBE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [4:0]        addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              err_q, err_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic [1:0]        off;
    logic [7:0]        byte_v;
    logic [15:0]       half_v;
    logic [DATA_W-1:0] load_v;
    logic [DATA_W-1:0] sel_data;
    logic              is_load;
    logic              misaligned;
    logic              accept;
    logic              eff_write;

    // Little-endian load extraction and alignment check from the byte offset.
    always_comb begin
        off = mem_alu_result[1:0];
        case (off)
            2'd0:    byte_v = mem_load_data[7:0];
            2'd1:    byte_v = mem_load_data[15:8];
            2'd2:    byte_v = mem_load_data[23:16];
            default: byte_v = mem_load_data[31:24];
        endcase
        half_v = off[1] ? mem_load_data[31:16] : mem_load_data[15:0];
        case (mem_load_type)
            3'b000: begin
                load_v     = {{24{byte_v[7]}}, byte_v};
                misaligned = 1'b0;
            end
            3'b100: begin
                load_v     = {24'd0, byte_v};
                misaligned = 1'b0;
            end
            3'b001: begin
                load_v     = {{16{half_v[15]}}, half_v};
                misaligned = off[0];
            end
            3'b101: begin
                load_v     = {16'd0, half_v};
                misaligned = off[0];
            end
            default: begin
                load_v     = mem_load_data;
                misaligned = (off != 2'd0);
            end
        endcase
    end

    // Writeback value select and acceptance/effective-write qualification.
    always_comb begin
        is_load = (mem_wb_sel == 2'b01);
        case (mem_wb_sel)
            2'b01:   sel_data = load_v;
            2'b10:   sel_data = mem_pc_plus4;
            default: sel_data = mem_alu_result;
        endcase
        mem_ready = (state_q != SETUP);
        accept    = mem_valid && mem_ready;
        eff_write = mem_reg_write && (mem_rd_addr != 5'd0) && !(is_load && misaligned);
    end

    // Next-state logic: a latched write always spends one SETUP then one STROBE cycle.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        err_d   = accept && mem_reg_write && is_load && misaligned;
        if (state_q == STROBE) begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
        case (state_q)
            SETUP: state_d = STROBE;
            IDLE, STROBE: begin
                state_d = IDLE;
                if (accept && eff_write) begin
                    addr_d  = mem_rd_addr;
                    data_d  = sel_data;
                    state_d = SETUP;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any write in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            addr_q  <= 5'd0;
            data_q  <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    // Outputs decoded straight from registered state.
    always_comb begin
        reg_wr_addr   = addr_q;
        reg_wr_data   = data_q;
        reg_wr_strobe = (state_q == STROBE);
        fwd_valid     = (state_q == SETUP) || (state_q == STROBE);
        fwd_addr      = addr_q;
        fwd_data      = data_q;
        err_misalign  = err_q;
        commit_count  = cnt_q;
    end

endmodule

// File: tb/tb_wb_commit_stage.sv
// Self-checking bench for wb_commit_stage: directed scenarios followed by
// randomized traffic checked against a cycle-timed reference model.
module tb_wb_commit_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mem_valid;
    logic        mem_ready;
    logic        mem_reg_write;
    logic [4:0]  mem_rd_addr;
    logic [1:0]  mem_wb_sel;
    logic [2:0]  mem_load_type;
    logic [31:0] mem_alu_result;
    logic [31:0] mem_load_data;
    logic [31:0] mem_pc_plus4;
    logic [4:0]  reg_wr_addr;
    logic [31:0] reg_wr_data;
    logic        reg_wr_strobe;
    logic        fwd_valid;
    logic [4:0]  fwd_addr;
    logic [31:0] fwd_data;
    logic        err_misalign;
    logic [31:0] commit_count;

    int total_cnt = 0;
    int pass_cnt  = 0;
    int exp_count = 0;

    wb_commit_stage #(.DATA_W(32), .CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .mem_valid(mem_valid), .mem_ready(mem_ready),
        .mem_reg_write(mem_reg_write), .mem_rd_addr(mem_rd_addr),
        .mem_wb_sel(mem_wb_sel), .mem_load_type(mem_load_type),
        .mem_alu_result(mem_alu_result), .mem_load_data(mem_load_data),
        .mem_pc_plus4(mem_pc_plus4),
        .reg_wr_addr(reg_wr_addr), .reg_wr_data(reg_wr_data),
        .reg_wr_strobe(reg_wr_strobe),
        .fwd_valid(fwd_valid), .fwd_addr(fwd_addr), .fwd_data(fwd_data),
        .err_misalign(err_misalign), .commit_count(commit_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    // Reference load value computed with plain arithmetic on the word.
    function automatic logic [31:0] ref_load(input logic [2:0] t, input int b, input logic [31:0] w);
        logic [31:0] by, hw;
        by = (w >> (8 * b)) & 32'hFF;
        hw = (w >> (16 * (b / 2))) & 32'hFFFF;
        case (t)
            3'b000:  return (by >= 32'd128) ? (by | 32'hFFFFFF00) : by;
            3'b100:  return by;
            3'b001:  return (hw >= 32'd32768) ? (hw | 32'hFFFF0000) : hw;
            3'b101:  return hw;
            default: return w;
        endcase
    endfunction

    function automatic bit ref_misaligned(input logic [2:0] t, input int b);
        if (t == 3'b000 || t == 3'b100) return 1'b0;
        if (t == 3'b001 || t == 3'b101) return (b % 2) != 0;
        return b != 0;
    endfunction

    task automatic drive(input logic v, input logic rw, input logic [4:0] rd, input logic [1:0] sel,
                         input logic [2:0] lt, input logic [31:0] alu, input logic [31:0] ld,
                         input logic [31:0] pc);
        mem_valid = v; mem_reg_write = rw; mem_rd_addr = rd; mem_wb_sel = sel;
        mem_load_type = lt; mem_alu_result = alu; mem_load_data = ld; mem_pc_plus4 = pc;
    endtask

    task automatic test_reset();
        logic [137:0] all_out;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b0;
        tick();
        all_out = {reg_wr_addr, reg_wr_data, reg_wr_strobe, fwd_valid, fwd_addr, fwd_data, err_misalign, commit_count};
        total_cnt++;
        if (all_out !== '0) $display("FAIL reset_outputs got=%h exp=0", all_out);
        else pass_cnt++;
        rst_n = 1'b1;
        drive(1, 1, 5'd9, 2'b00, 3'b010, 32'hDEADBEEF, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        total_cnt++;
        if ({fwd_valid, reg_wr_strobe, mem_ready} !== 3'b100)
            $display("FAIL reset_setup_entry got=%b exp=100", {fwd_valid, reg_wr_strobe, mem_ready});
        else pass_cnt++;
        #1 rst_n = 1'b0;
        #1;
        all_out = {reg_wr_addr, reg_wr_data, reg_wr_strobe, fwd_valid, fwd_addr, fwd_data, err_misalign, commit_count};
        total_cnt++;
        if (all_out !== '0) $display("FAIL reset_async_clear got=%h exp=0", all_out);
        else pass_cnt++;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            total_cnt++;
            if (reg_wr_strobe !== 1'b0 || commit_count !== 32'd0)
                $display("FAIL reset_no_strobe cyc=%0d strobe=%b count=%0d exp strobe=0 count=0", i, reg_wr_strobe, commit_count);
            else pass_cnt++;
        end
    endtask

    task automatic test_alu_write();
        drive(1, 1, 5'd5, 2'b00, 3'b010, 32'h12345678, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        total_cnt++;
        if (reg_wr_addr !== 5'd5 || reg_wr_data !== 32'h12345678 || reg_wr_strobe !== 1'b0 || mem_ready !== 1'b0)
            $display("FAIL alu_setup addr=%0d data=%h strobe=%b ready=%b exp 5 12345678 0 0", reg_wr_addr, reg_wr_data, reg_wr_strobe, mem_ready);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (reg_wr_strobe !== 1'b1 || reg_wr_addr !== 5'd5 || reg_wr_data !== 32'h12345678)
            $display("FAIL alu_strobe strobe=%b addr=%0d data=%h exp 1 5 12345678", reg_wr_strobe, reg_wr_addr, reg_wr_data);
        else pass_cnt++;
        exp_count++;
        tick();
        total_cnt++;
        if (reg_wr_strobe !== 1'b0 || commit_count !== exp_count)
            $display("FAIL alu_after strobe=%b count=%0d exp 0 %0d", reg_wr_strobe, commit_count, exp_count);
        else pass_cnt++;
    endtask

    task automatic test_load_extract();
        logic [2:0]  lt [4] = '{3'b000, 3'b100, 3'b001, 3'b101};
        int          of [4] = '{3, 3, 2, 0};
        logic [31:0] ex [4] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80FF, 32'h00007F01};
        for (int i = 0; i < 4; i++) begin
            drive(1, 1, 5'(10 + i), 2'b01, lt[i], 32'h1000 + 32'(of[i]), 32'h80FF7F01, 0);
            tick();
            drive(0, 0, 0, 0, 0, 0, 0, 0);
            total_cnt++;
            if (reg_wr_data !== ex[i] || reg_wr_addr !== 5'(10 + i))
                $display("FAIL load_extract idx=%0d data=%h addr=%0d exp %h %0d", i, reg_wr_data, reg_wr_addr, ex[i], 10 + i);
            else pass_cnt++;
            tick();
            exp_count++;
            tick();
        end
    endtask

    task automatic test_back_to_back();
        logic       rdy [8] = '{1, 0, 1, 0, 1, 0, 1, 1};
        logic       stb [8] = '{0, 0, 1, 0, 1, 0, 1, 0};
        logic [4:0] adr [8] = '{0, 1, 1, 2, 2, 3, 3, 3};
        drive(1, 1, 5'd1, 2'b00, 3'b010, 32'h111, 0, 0);
        for (int k = 0; k < 8; k++) begin
            total_cnt++;
            if (mem_ready !== rdy[k] || reg_wr_strobe !== stb[k] || (k > 0 && reg_wr_addr !== adr[k]))
                $display("FAIL b2b cyc=%0d ready=%b strobe=%b addr=%0d exp %b %b %0d", k, mem_ready, reg_wr_strobe, reg_wr_addr, rdy[k], stb[k], adr[k]);
            else pass_cnt++;
            if (stb[k]) exp_count++;
            if (k == 1) drive(1, 1, 5'd2, 2'b00, 3'b010, 32'h222, 0, 0);
            if (k == 3) drive(1, 1, 5'd3, 2'b00, 3'b010, 32'h333, 0, 0);
            if (k == 5) drive(0, 0, 0, 0, 0, 0, 0, 0);
            tick();
        end
        total_cnt++;
        if (commit_count !== exp_count) $display("FAIL b2b_count got=%0d exp=%0d", commit_count, exp_count);
        else pass_cnt++;
    endtask

    task automatic test_suppression();
        drive(1, 1, 5'd0, 2'b00, 3'b010, 32'hABCD, 0, 0);
        tick();
        drive(1, 1, 5'd7, 2'b01, 3'b010, 32'h1002, 32'h55AA55AA, 0);
        total_cnt++;
        if (reg_wr_strobe !== 1'b0 || fwd_valid !== 1'b0 || err_misalign !== 1'b0 || mem_ready !== 1'b1)
            $display("FAIL suppress_rd0 strobe=%b fwd=%b err=%b ready=%b exp 0 0 0 1", reg_wr_strobe, fwd_valid, err_misalign, mem_ready);
        else pass_cnt++;
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        total_cnt++;
        if (reg_wr_strobe !== 1'b0 || fwd_valid !== 1'b0 || err_misalign !== 1'b1 || mem_ready !== 1'b1)
            $display("FAIL suppress_lw strobe=%b fwd=%b err=%b ready=%b exp 0 0 1 1", reg_wr_strobe, fwd_valid, err_misalign, mem_ready);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (reg_wr_strobe !== 1'b0 || err_misalign !== 1'b0)
            $display("FAIL suppress_after strobe=%b err=%b exp 0 0", reg_wr_strobe, err_misalign);
        else pass_cnt++;
    endtask

    task automatic test_link_fwd();
        drive(1, 1, 5'd31, 2'b10, 3'b010, 32'h9999, 0, 32'h00400010);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            total_cnt++;
            if (k < 2 && (fwd_valid !== 1'b1 || fwd_addr !== 5'd31 || fwd_data !== 32'h00400010))
                $display("FAIL link_fwd cyc=%0d valid=%b addr=%0d data=%h exp 1 31 00400010", k, fwd_valid, fwd_addr, fwd_data);
            else if (k == 2 && fwd_valid !== 1'b0)
                $display("FAIL link_fwd_idle valid=%b exp 0", fwd_valid);
            else pass_cnt++;
            if (k == 1) exp_count++;
            tick();
        end
    endtask

    // Timing model: a write accepted in cycle w is in setup at w+1 and strobes at w+2.
    task automatic test_random();
        int          w = -10;
        int          err_at = -10;
        logic [4:0]  m_addr = 0;
        logic [31:0] m_data = 0;
        logic [2:0]  lts [7] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b011, 3'b111};
        for (int c = 0; c < 400; c++) begin
            bit e_ready, e_strobe, e_fwd, e_err, v, rw, ld, mis, eff;
            logic [4:0]  rd;
            logic [1:0]  sel;
            logic [2:0]  lt;
            logic [31:0] alu, ldw, pc, val;
            e_ready  = (c != w + 1);
            e_strobe = (c == w + 2);
            e_fwd    = (c == w + 1) || (c == w + 2);
            e_err    = (c == err_at);
            total_cnt++;
            if (mem_ready !== e_ready || reg_wr_strobe !== e_strobe || fwd_valid !== e_fwd || err_misalign !== e_err)
                $display("FAIL rand_ctrl cyc=%0d rdy/stb/fwd/err=%b%b%b%b exp %b%b%b%b", c, mem_ready, reg_wr_strobe, fwd_valid, err_misalign, e_ready, e_strobe, e_fwd, e_err);
            else pass_cnt++;
            if (e_fwd) begin
                total_cnt++;
                if (reg_wr_addr !== m_addr || reg_wr_data !== m_data || fwd_addr !== m_addr || fwd_data !== m_data)
                    $display("FAIL rand_data cyc=%0d addr=%0d data=%h exp %0d %h", c, reg_wr_addr, reg_wr_data, m_addr, m_data);
                else pass_cnt++;
            end
            total_cnt++;
            if (commit_count !== exp_count) $display("FAIL rand_count cyc=%0d got=%0d exp=%0d", c, commit_count, exp_count);
            else pass_cnt++;
            if (e_strobe) exp_count++;
            v   = (c < 390) && ($urandom_range(0, 9) < 7);
            rw  = ($urandom_range(0, 9) < 8);
            rd  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
            sel = 2'($urandom);
            lt  = lts[$urandom_range(0, 6)];
            alu = $urandom; ldw = $urandom; pc = $urandom;
            drive(v, rw, rd, sel, lt, alu, ldw, pc);
            ld  = (sel == 2'b01);
            mis = ld && ref_misaligned(lt, int'(alu[1:0]));
            val = ld ? ref_load(lt, int'(alu[1:0]), ldw) : (sel == 2'b10) ? pc : alu;
            eff = rw && (rd != 0) && !mis;
            if (v && e_ready) begin
                if (eff) begin
                    w = c; m_addr = rd; m_data = val;
                end
                if (rw && mis) err_at = c + 1;
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_alu_write();
        test_load_extract();
        test_back_to_back();
        test_suppression();
        test_link_fwd();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
